wb_mem_arbiter: RTL and testbench

//  Two-master Wishbone arbiter sharing one memory port between the instruction-fetch path
//  (master I: stb/cyc/ack handshake of the FETCH state) and the data path (master D: data_stb/

---
 rtl/wb_mem_arbiter_if.sv | 52 +++++
 rtl/wb_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle between the two Wishbone masters (I fetch, D data), the arbiter and the memory port.
// The arbiter uses the slave modport; the master modport is the environment's view of it.
interface wb_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          i_cyc_i;
    logic          i_stb_i;
    logic [AW-1:0] i_adr_i;
    logic [DW-1:0] i_dat_o;
    logic          i_ack_o;
    logic          i_err_o;

    logic          d_cyc_i;
    logic          d_stb_i;
    logic          d_we_i;
    logic [AW-1:0] d_adr_i;
    logic [DW-1:0] d_dat_i;
    logic [DW-1:0] d_dat_o;
    logic          d_ack_o;
    logic          d_err_o;

    logic          s_cyc_o;
    logic          s_stb_o;
    logic          s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;

    logic [1:0]    gnt_o;

    modport slave (
        input  i_cyc_i, i_stb_i, i_adr_i,
        output i_dat_o, i_ack_o, i_err_o,
        input  d_cyc_i, d_stb_i, d_we_i, d_adr_i, d_dat_i,
        output d_dat_o, d_ack_o, d_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i,
        output gnt_o
    );

    modport master (
        output i_cyc_i, i_stb_i, i_adr_i,
        input  i_dat_o, i_ack_o, i_err_o,
        output d_cyc_i, d_stb_i, d_we_i, d_adr_i, d_dat_i,
        input  d_dat_o, d_ack_o, d_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i,
        input  gnt_o
    );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter (I fetch / D data) onto one memory port, burst-held round-robin grant.
// Define WB_TIMEOUT_EN to abort transfers whose slave fails to ack within TIMEOUT_CYC strobe cycles.
module wb_mem_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    wb_mem_arbiter_if.slave   bus
);

`ifdef WB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
`endif

    state_t state_q, state_d;
    logic   timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: D wins ties from IDLE; on release the other master is taken with no idle gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.d_cyc_i) begin
                    state_d = GNT_D;
                end else if (bus.i_cyc_i) begin
                    state_d = GNT_I;
                end
            end
            GNT_I: begin
`ifdef WB_TIMEOUT_EN
                if (timeout_hit) begin
                    state_d = ABORT;
                end else
`endif
                if (!bus.i_cyc_i) begin
                    state_d = bus.d_cyc_i ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
`ifdef WB_TIMEOUT_EN
                if (timeout_hit) begin
                    state_d = ABORT;
                end else
`endif
                if (!bus.d_cyc_i) begin
                    state_d = bus.i_cyc_i ? GNT_I : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a pure function of the state and the holder's inputs.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.i_ack_o = 1'b0;
        bus.d_ack_o = 1'b0;
        bus.i_err_o = 1'b0;
        bus.d_err_o = 1'b0;
        bus.gnt_o   = 2'b00;
        case (state_q)
            GNT_I: begin
                bus.gnt_o   = 2'b01;
                bus.s_cyc_o = bus.i_cyc_i;
                bus.s_stb_o = bus.i_stb_i;
                bus.s_adr_o = bus.i_adr_i;
                bus.i_ack_o = bus.s_ack_i & bus.i_stb_i;
                bus.i_err_o = timeout_hit;
            end
            GNT_D: begin
                bus.gnt_o   = 2'b10;
                bus.s_cyc_o = bus.d_cyc_i;
                bus.s_stb_o = bus.d_stb_i;
                bus.s_we_o  = bus.d_we_i;
                bus.s_adr_o = bus.d_adr_i;
                bus.s_dat_o = bus.d_dat_i;
                bus.d_ack_o = bus.s_ack_i & bus.d_stb_i;
                bus.d_err_o = timeout_hit;
            end
            default: ;
        endcase
    end

    assign bus.i_dat_o = bus.s_dat_i;
    assign bus.d_dat_o = bus.s_dat_i;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             granted;

    assign granted     = (state_q == GNT_I) || (state_q == GNT_D);
    assign timeout_hit = granted && (cnt_q == CNT_W'(TIMEOUT_CYC));

    // Counts consecutive unanswered strobe cycles of the current holder.
    always_comb begin
        cnt_d = cnt_q;
        if (!granted || (state_d != state_q) || bus.s_ack_i) begin
            cnt_d = '0;
        end else if (bus.s_stb_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-owner reference model. Follows WB_TIMEOUT_EN the same way the design does.
module tb_wb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_cyc_i = 0; bus.i_stb_i = 0; bus.i_adr_i = '0;
        bus.d_cyc_i = 0; bus.d_stb_i = 0; bus.d_we_i = 0; bus.d_adr_i = '0; bus.d_dat_i = '0;
        bus.s_ack_i = 0; bus.s_dat_i = '0;
    endtask

    task automatic idle_all();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; bus.i_cyc_i = 1; bus.d_cyc_i = 1;
        tick(); tick();
        total++;
        if ({bus.gnt_o, bus.s_cyc_o, bus.i_ack_o, bus.d_ack_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b s_cyc=%b i_ack=%b d_ack=%b, want all 0",
                     bus.gnt_o, bus.s_cyc_o, bus.i_ack_o, bus.d_ack_o);
        end
        rst = 0;
        tick();
        total++;
        if (bus.gnt_o !== 2'b10) begin
            bad++;
            $display("FAIL reset_tie_d_wins: got gnt=%b want 10", bus.gnt_o);
        end
        $display("reset: gnt after release=%b", bus.gnt_o);
        idle_all();
    endtask

    task automatic test_fetch();
        bus.i_cyc_i = 1; bus.i_stb_i = 1; bus.i_adr_i = 16'h0040;
        tick();
        total++;
        if ({bus.gnt_o, bus.s_stb_o, bus.s_we_o} !== 4'b0110 || bus.s_adr_o !== 16'h0040) begin
            bad++;
            $display("FAIL fetch_grant: got gnt=%b stb=%b we=%b adr=%h want 01 1 0 0040",
                     bus.gnt_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o);
        end
        tick();
        bus.s_ack_i = 1; bus.s_dat_i = 32'hCAFE_F00D;
        #1;
        total++;
        if (bus.i_ack_o !== 1'b1 || bus.d_ack_o !== 1'b0 || bus.i_dat_o !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL fetch_ack: got i_ack=%b d_ack=%b i_dat=%h want 1 0 cafef00d",
                     bus.i_ack_o, bus.d_ack_o, bus.i_dat_o);
        end
        $display("fetch: adr=%h dat=%h ack=%b", bus.s_adr_o, bus.i_dat_o, bus.i_ack_o);
        bus.i_cyc_i = 0; bus.i_stb_i = 0; bus.s_ack_i = 0;
        tick();
        total++;
        if (bus.gnt_o !== 2'b00) begin
            bad++;
            $display("FAIL fetch_release: got gnt=%b want 00", bus.gnt_o);
        end
        idle_all();
    endtask

    task automatic test_contention();
        bus.d_cyc_i = 1; bus.d_stb_i = 1; bus.d_we_i = 1; bus.d_adr_i = 16'h1000;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.d_adr_i = 16'(16'h1000 + k);
            bus.d_dat_i = 32'hA5A5_0000 + 32'(k);
            bus.s_ack_i = 1;
            if (k == 1) begin
                bus.i_cyc_i = 1; bus.i_stb_i = 1; bus.i_adr_i = 16'h0200;
            end
            #1;
            total++;
            if (bus.gnt_o !== 2'b10 || bus.s_we_o !== 1'b1 || bus.s_adr_o !== 16'(16'h1000 + k) ||
                bus.s_dat_o !== 32'hA5A5_0000 + 32'(k) || bus.d_ack_o !== 1'b1 || bus.i_ack_o !== 1'b0) begin
                bad++;
                $display("FAIL contention_beat%0d: got gnt=%b we=%b adr=%h dat=%h d_ack=%b i_ack=%b",
                         k, bus.gnt_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.d_ack_o, bus.i_ack_o);
            end
            $display("contention: beat %0d adr=%h dat=%h", k, bus.s_adr_o, bus.s_dat_o);
            tick();
        end
        bus.d_cyc_i = 0; bus.d_stb_i = 0; bus.d_we_i = 0; bus.s_ack_i = 0;
        #1;
        total++;
        if (bus.gnt_o !== 2'b10 || bus.s_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL contention_release: got gnt=%b s_cyc=%b want 10 0", bus.gnt_o, bus.s_cyc_o);
        end
        tick();
        total++;
        if (bus.gnt_o !== 2'b01 || bus.s_adr_o !== 16'h0200 || bus.s_cyc_o !== 1'b1) begin
            bad++;
            $display("FAIL contention_handover: got gnt=%b adr=%h s_cyc=%b want 01 0200 1",
                     bus.gnt_o, bus.s_adr_o, bus.s_cyc_o);
        end
        idle_all();
    endtask

    task automatic test_round_robin();
        int holder;
        bus.i_cyc_i = 1; bus.i_stb_i = 1; bus.d_cyc_i = 1; bus.d_stb_i = 1; bus.s_ack_i = 1;
        tick();
        holder = 2;
        for (int g = 0; g < 6; g++) begin
            total++;
            if (bus.gnt_o !== 2'(holder) || bus.i_ack_o !== (holder == 1) || bus.d_ack_o !== (holder == 2)) begin
                bad++;
                $display("FAIL round_robin_grant%0d: got gnt=%b i_ack=%b d_ack=%b want gnt=%0d",
                         g, bus.gnt_o, bus.i_ack_o, bus.d_ack_o, holder);
            end
            $display("round_robin: grant %0d gnt=%b", g, bus.gnt_o);
            if (holder == 2) begin bus.d_cyc_i = 0; bus.d_stb_i = 0; end
            else begin bus.i_cyc_i = 0; bus.i_stb_i = 0; end
            tick();
            bus.i_cyc_i = 1; bus.i_stb_i = 1; bus.d_cyc_i = 1; bus.d_stb_i = 1;
            #1;
            holder = 3 - holder;
        end
        idle_all();
    endtask

    task automatic test_reset_mid_write();
        bus.d_cyc_i = 1; bus.d_stb_i = 1; bus.d_we_i = 1; bus.d_adr_i = 16'h2222;
        tick();
        total++;
        if (bus.gnt_o !== 2'b10 || bus.s_stb_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_setup: got gnt=%b s_stb=%b want 10 1", bus.gnt_o, bus.s_stb_o);
        end
        rst = 1; bus.s_ack_i = 1;
        tick();
        total++;
        if ({bus.gnt_o, bus.s_cyc_o, bus.s_we_o, bus.d_ack_o, bus.i_ack_o} !== 6'b0) begin
            bad++;
            $display("FAIL rst_mid_write: got gnt=%b s_cyc=%b s_we=%b d_ack=%b i_ack=%b want all 0",
                     bus.gnt_o, bus.s_cyc_o, bus.s_we_o, bus.d_ack_o, bus.i_ack_o);
        end
        $display("reset_mid_write: gnt=%b d_ack=%b", bus.gnt_o, bus.d_ack_o);
        clear_inputs();
        tick();
        rst = 0;
        idle_all();
    endtask

    task automatic test_timeout();
        int errs = 0;
        logic [1:0] eg;
        logic       ee, ec;
        bus.i_cyc_i = 1; bus.i_stb_i = 1; bus.i_adr_i = 16'h0300;
        tick();
        for (int idx = 0; idx < 6; idx++) begin
`ifdef WB_TIMEOUT_EN
            ee = (idx == TO);
            eg = (idx <= TO) ? 2'b01 : 2'b00;
            ec = (idx <= TO);
`else
            ee = 1'b0; eg = 2'b01; ec = 1'b1;
`endif
            if (bus.i_err_o === 1'b1) errs++;
            total++;
            if (bus.gnt_o !== eg || bus.i_err_o !== ee || bus.s_cyc_o !== ec || bus.d_err_o !== 1'b0) begin
                bad++;
                $display("FAIL timeout_cycle%0d: got gnt=%b i_err=%b s_cyc=%b d_err=%b want %b %b %b 0",
                         idx, bus.gnt_o, bus.i_err_o, bus.s_cyc_o, bus.d_err_o, eg, ee, ec);
            end
            if (idx < 5) tick();
        end
        bus.i_cyc_i = 0; bus.i_stb_i = 0;
        tick();
        total++;
`ifdef WB_TIMEOUT_EN
        if (errs != 1 || bus.gnt_o !== 2'b00) begin
`else
        if (errs != 0 || bus.gnt_o !== 2'b00) begin
`endif
            bad++;
            $display("FAIL timeout_summary: got err_pulses=%0d gnt=%b", errs, bus.gnt_o);
        end
        $display("timeout: err pulses=%0d", errs);
        idle_all();
    endtask

    // Reference model: tracks which master owns the port and how long the owner has stalled.
    task automatic test_random();
        int owner = 0;   // 0 none, 1 I, 2 D, 3 aborted
        int stall = 0;
        int next_owner;
        logic p_rst, p_icyc, p_istb, p_dcyc, p_dstb, p_ack;
        logic [8:0]    got_ctrl, exp_ctrl;
        logic [AW-1:0] exp_adr;
        logic [DW-1:0] exp_dat;
        logic          h_cyc, h_stb, h_err;
        int            errs_seen = 0;
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
        for (int c = 0; c < 3000; c++) begin
            h_cyc = (owner == 1) ? bus.i_cyc_i : (owner == 2) ? bus.d_cyc_i : 1'b0;
            h_stb = (owner == 1) ? bus.i_stb_i : (owner == 2) ? bus.d_stb_i : 1'b0;
`ifdef WB_TIMEOUT_EN
            h_err = (owner == 1 || owner == 2) && (stall == TO);
`else
            h_err = 1'b0;
`endif
            exp_adr  = (owner == 1) ? bus.i_adr_i : (owner == 2) ? bus.d_adr_i : '0;
            exp_dat  = (owner == 2) ? bus.d_dat_i : '0;
            exp_ctrl = {(owner == 2), (owner == 1), h_cyc, h_stb, (owner == 2) & bus.d_we_i,
                        (owner == 1) & h_stb & bus.s_ack_i, (owner == 2) & h_stb & bus.s_ack_i,
                        (owner == 1) & h_err, (owner == 2) & h_err};
            got_ctrl = {bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
                        bus.i_ack_o, bus.d_ack_o, bus.i_err_o, bus.d_err_o};
            if (h_err) errs_seen++;
            total++;
            if (got_ctrl !== exp_ctrl || bus.s_adr_o !== exp_adr || bus.s_dat_o !== exp_dat ||
                bus.i_dat_o !== bus.s_dat_i || bus.d_dat_o !== bus.s_dat_i) begin
                bad++;
                $display("FAIL random_cycle%0d: got ctrl=%b adr=%h dat=%h want ctrl=%b adr=%h dat=%h",
                         c, got_ctrl, bus.s_adr_o, bus.s_dat_o, exp_ctrl, exp_adr, exp_dat);
            end
            p_rst = rst; p_icyc = bus.i_cyc_i; p_istb = bus.i_stb_i;
            p_dcyc = bus.d_cyc_i; p_dstb = bus.d_stb_i; p_ack = bus.s_ack_i;
            tick();
            if (p_rst) begin
                next_owner = 0;
            end else if (owner == 0) begin
                next_owner = p_dcyc ? 2 : (p_icyc ? 1 : 0);
            end else if (owner == 3 || h_err) begin
                next_owner = (owner == 3) ? 0 : 3;
            end else if ((owner == 1 ? p_icyc : p_dcyc)) begin
                next_owner = owner;
            end else begin
                next_owner = (owner == 1 ? p_dcyc : p_icyc) ? 3 - owner : 0;
            end
            if (next_owner != owner || p_ack || owner == 0 || owner == 3) stall = 0;
            else if ((owner == 1 ? p_istb : p_dstb)) stall++;
            owner = next_owner;
            rst = ($urandom_range(63) == 0);
            if ($urandom_range(3) == 0) bus.i_cyc_i = !bus.i_cyc_i;
            if ($urandom_range(3) == 0) bus.d_cyc_i = !bus.d_cyc_i;
            bus.i_stb_i = bus.i_cyc_i & 1'($urandom_range(1));
            bus.d_stb_i = bus.d_cyc_i & 1'($urandom_range(1));
            bus.d_we_i  = 1'($urandom_range(1));
            bus.i_adr_i = 16'($urandom);
            bus.d_adr_i = 16'($urandom);
            bus.d_dat_i = $urandom;
            bus.s_dat_i = $urandom;
            bus.s_ack_i = 1'($urandom_range(1));
            #1;
        end
        $display("random: 3000 cycles, modelled timeouts=%0d", errs_seen);
        rst = 0;
        idle_all();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        test_reset();
        test_fetch();
        test_contention();
        test_round_robin();
        test_reset_mid_write();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
